// File: rtl/wb_stage.sv
// wb_stage: two-entry (main + skid) writeback stage with load alignment and result select.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_wen,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [1:0]         in_sel,
  input  logic [XLEN-1:0]    in_alu,
  input  logic [XLEN-1:0]    in_mem,
  input  logic [XLEN-1:0]    in_pc4,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_uns,
  input  logic [2:0]         in_addr_lo,
  input  logic               flush,
  input  logic               out_ready,
  output logic               wb_valid,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic [CNT_W-1:0]   retire_cnt
);
  localparam bit X64 = (XLEN == 64);
  logic               main_v, main_we, skid_v, skid_we, rdy;
  logic [RADDR_W-1:0] main_rd, skid_rd;
  logic [XLEN-1:0]    main_data, skid_data;
  logic [2:0]         boff;
  logic [XLEN-1:0]    sh, ld, cap_data;
  logic               cap_we, in_xfer, out_xfer;
  // Byte offset of the selected lane; the shifted word then only needs extension.
  always_comb begin
    boff = in_ld_size == 2'd0 ? (X64 ? in_addr_lo : {1'b0, in_addr_lo[1:0]})
         : in_ld_size == 2'd1 ? (X64 ? {in_addr_lo[2:1], 1'b0} : {1'b0, in_addr_lo[1], 1'b0})
         : (in_ld_size == 2'd2 && X64) ? {in_addr_lo[2], 2'b00} : 3'd0;
    sh = in_mem >> {boff, 3'b000};
    ld = in_ld_size == 2'd0 ? (in_ld_uns ? XLEN'(sh[7:0]) : XLEN'($signed(sh[7:0])))
       : in_ld_size == 2'd1 ? (in_ld_uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0])))
       : (in_ld_size == 2'd2 && X64) ? (in_ld_uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0])))
       : in_mem;
    cap_data = in_sel == 2'd0 ? in_alu
             : in_sel == 2'd1 ? ld
             : in_sel == 2'd2 ? in_pc4 : in_imm;
    cap_we = in_wen && (in_rd != '0);
  end
  assign in_xfer  = in_valid && rdy;
  assign out_xfer = main_v && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v    <= 1'b0;
      main_we   <= 1'b0;
      main_rd   <= '0;
      main_data <= '0;
      skid_v    <= 1'b0;
      skid_we   <= 1'b0;
      skid_rd   <= '0;
      skid_data <= '0;
      rdy       <= 1'b1;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy    <= 1'b1;
    end else if (out_xfer && skid_v) begin
      main_v    <= 1'b1;
      main_we   <= skid_we;
      main_rd   <= skid_rd;
      main_data <= skid_data;
      skid_v    <= 1'b0;
      rdy       <= 1'b1;
    end else if (in_xfer && (!main_v || out_xfer)) begin
      main_v    <= 1'b1;
      main_we   <= cap_we;
      main_rd   <= in_rd;
      main_data <= cap_data;
    end else if (in_xfer) begin
      skid_v    <= 1'b1;
      skid_we   <= cap_we;
      skid_rd   <= in_rd;
      skid_data <= cap_data;
      rdy       <= 1'b0;
    end else if (out_xfer) begin
      main_v <= 1'b0;
    end
  end
  assign in_ready = rdy;
  assign wb_valid = main_v;
  assign wb_we    = main_v && main_we;
  assign wb_rd    = main_rd;
  assign wb_data  = main_data;
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (out_xfer && !flush) cnt <= cnt + 1'b1;
  end
  assign retire_cnt = cnt;
`else
  assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized + directed bench for wb_stage against a two-deep FIFO reference model.
module tb_wb_stage;
  localparam int XLEN = 32, RW = 5, CW = 4;
  logic            clk = 0, rst = 1;
  logic            in_valid = 0, in_ready, in_wen = 0, in_ld_uns = 0, flush = 0, out_ready = 0;
  logic [RW-1:0]   in_rd = '0;
  logic [1:0]      in_sel = '0, in_ld_size = '0;
  logic [XLEN-1:0] in_alu = '0, in_mem = '0, in_pc4 = '0, in_imm = '0;
  logic [2:0]      in_addr_lo = '0;
  logic            wb_valid, wb_we;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [CW-1:0]   retire_cnt;

  wb_stage #(.XLEN(XLEN), .RADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_rd(in_rd), .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem), .in_pc4(in_pc4),
    .in_imm(in_imm), .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns), .in_addr_lo(in_addr_lo),
    .flush(flush), .out_ready(out_ready), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] exp_cnt(int n);
`ifdef WB_RETIRE_CNT_EN
    return CW'(n % (1 << CW));
`else
    return '0;
`endif
  endfunction

  typedef struct {
    logic          we;
    logic [RW-1:0] rd;
    logic [31:0]   data;
  } ent_t;
  ent_t q[$];
  int   rcount = 0;
  bit   can_in;

  function automatic logic [31:0] ld_ref(logic [31:0] m, logic [1:0] sz, logic u, logic [2:0] a);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (m >> (8 * a[1:0])) & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (m >> (16 * a[1])) & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else v = m;
    return v;
  endfunction

  function automatic ent_t mk();
    ent_t e;
    e.we = in_wen && (in_rd != 0);
    e.rd = in_rd;
    case (in_sel)
      2'd0: e.data = in_alu;
      2'd1: e.data = ld_ref(in_mem, in_ld_size, in_ld_uns, in_addr_lo);
      2'd2: e.data = in_pc4;
      default: e.data = in_imm;
    endcase
    return e;
  endfunction

  // Reference: the stage behaves as a two-deep FIFO whose head is the output.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      rcount = 0;
    end else if (flush) q.delete();
    else begin
      can_in = q.size() < 2;
      if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
        rcount++;
      end
      if (in_valid && can_in) q.push_back(mk());
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("in_ready", in_ready, q.size() < 2);
    chk("wb_valid", wb_valid, q.size() > 0);
    chk("wb_we", wb_we, q.size() > 0 && q[0].we);
    if (q.size() > 0) begin
      chk("wb_rd", wb_rd, q[0].rd);
      chk("wb_data", wb_data, q[0].data);
    end
    chk("retire_cnt", retire_cnt, exp_cnt(rcount));
  end

  task automatic put_ld(logic [31:0] m, logic [1:0] sz, logic u, logic [2:0] a);
    in_valid = 1; in_wen = 1; in_rd = 5'd3; in_sel = 2'd1;
    in_mem = m; in_ld_size = sz; in_ld_uns = u; in_addr_lo = a;
  endtask

  task automatic put_alu(logic v, logic [31:0] val, logic [RW-1:0] rd);
    in_valid = v; in_wen = 1; in_rd = rd; in_sel = 2'd0; in_alu = val;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_we", wb_we, 0);
    chk("rst wb_rd", wb_rd, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst retire_cnt", retire_cnt, 0);
    chk_en = 1;
    out_ready = 1;
    put_ld(32'h80FF_7F01, 2'd0, 0, 3'd1);
    @(negedge clk) chk("byte lane1", wb_data, 32'h0000_007F);
    chk("byte we", wb_we, 1);
    put_ld(32'h80FF_7F01, 2'd0, 0, 3'd2);
    @(negedge clk) chk("byte lane2", wb_data, 32'hFFFF_FFFF);
    put_ld(32'h8001_1234, 2'd1, 0, 3'd2);
    @(negedge clk) chk("half signed", wb_data, 32'hFFFF_8001);
    put_ld(32'h8001_1234, 2'd1, 1, 3'd2);
    @(negedge clk) chk("half unsigned", wb_data, 32'h0000_8001);
    put_alu(1, 32'h1234, 5'd0);
    @(negedge clk);
    chk("rd0 valid", wb_valid, 1);
    chk("rd0 we", wb_we, 0);
    chk("rd0 data", wb_data, 32'h1234);
    in_valid = 0;
    @(negedge clk);
    chk("rd0 retired", retire_cnt, exp_cnt(5));
    chk("idle valid", wb_valid, 0);
    out_ready = 0;
    put_alu(1, 32'hA, 5'd1);
    @(negedge clk) chk("bp A ready", in_ready, 1);
    put_alu(1, 32'hB, 5'd2);
    @(negedge clk) chk("bp B ready", in_ready, 0);
    chk("bp hold A", wb_data, 32'hA);
    put_alu(1, 32'hC, 5'd3);
    @(negedge clk) chk("bp still A", wb_data, 32'hA);
    out_ready = 1;
    @(negedge clk) chk("bp out B", wb_data, 32'hB);
    @(negedge clk) chk("bp out C", wb_data, 32'hC);
    in_valid = 0;
    @(negedge clk) chk("bp drained", wb_valid, 0);
    chk("bp count", retire_cnt, exp_cnt(8));
    out_ready = 0;
    put_alu(1, 32'hD, 5'd4);
    @(negedge clk) put_alu(1, 32'hE, 5'd5);
    @(negedge clk) put_alu(1, 32'hF, 5'd6);
    flush = 1;
    out_ready = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("flush valid", wb_valid, 0);
    chk("flush we", wb_we, 0);
    chk("flush ready", in_ready, 1);
    chk("flush count", retire_cnt, exp_cnt(8));
    for (int i = 0; i < 9; i++) begin
      put_alu(1, 32'h100 + i, 5'd7);
      @(negedge clk);
    end
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("wrap count", retire_cnt, exp_cnt(17));
    out_ready = 0;
    put_alu(1, 32'h55, 5'd8);
    @(negedge clk) put_alu(1, 32'h66, 5'd9);
    @(negedge clk) rst = 1;
    in_valid = 0;
    @(negedge clk) rst = 0;
    chk("mid rst valid", wb_valid, 0);
    chk("mid rst we", wb_we, 0);
    chk("mid rst ready", in_ready, 1);
    chk("mid rst count", retire_cnt, 0);
    for (int i = 0; i < 3000; i++) begin
      in_valid   = $urandom_range(0, 9) < 7;
      out_ready  = $urandom_range(0, 9) < 6;
      flush      = $urandom_range(0, 99) < 3;
      rst        = $urandom_range(0, 199) == 0;
      in_wen     = $urandom_range(0, 3) != 0;
      in_rd      = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
      in_sel     = 2'($urandom);
      in_alu     = $urandom;
      in_mem     = $urandom;
      in_pc4     = $urandom;
      in_imm     = $urandom;
      in_ld_size = 2'($urandom_range(0, 2));
      in_ld_uns  = 1'($urandom);
      in_addr_lo = 3'($urandom);
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width in bits; legal values 32 or 64.
REQ-002 Parameter RADDR_W, default 5: destination register address width.
REQ-003 Parameter CNT_W, default 32: retire counter width (used only with WB_RETIRE_CNT_EN).
REQ-004 The clock SHALL be clk and the reset SHALL be rst; there SHALL be one clock, and rst SHALL be synchronous and active-high.
REQ-005 Ports SHALL be as follows, one per line as name, direction, width, meaning:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_wen  in  1  entry writes a register
in_rd  in  RADDR_W  destination register
in_sel  in  2  result source: 0=ALU, 1=MEM, 2=PC4, 3=IMM
in_alu  in  XLEN  ALU result
in_mem  in  XLEN  raw memory read word
in_pc4  in  XLEN  link address
in_imm  in  XLEN  upper-immediate result
in_ld_size  in  2  load size: 0=byte, 1=half, 2=word, 3=dword (dword only when XLEN=64)
in_ld_uns  in  1  zero-extend the load
in_addr_lo  in  3  low bits of the load address
flush  in  1  discard all buffered entries
out_ready  in  1  register-file port accepts the output this cycle
wb_valid  out  1  output entry valid
wb_we  out  1  register write strobe
wb_rd  out  RADDR_W  write address
wb_data  out  XLEN  write data
retire_cnt  out  CNT_W  retired entries (WB_RETIRE_CNT_EN only)

Function
REQ-006 The stage SHALL hold two storage entries, main and skid; outputs SHALL be driven from main.
REQ-007 in_ready SHALL be a register equal to "skid empty"; it SHALL NOT depend combinationally on out_ready.
REQ-008 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when wb_valid && out_ready.
REQ-009 On an input transfer with main empty, or with main draining in the same cycle and skid empty, the entry SHALL load into main; otherwise it SHALL load into skid.
REQ-010 On an output transfer with skid full, skid SHALL move to main and skid SHALL become empty.
REQ-011 Latency SHALL be one cycle: an input accepted at edge N is on wb_* after edge N. Sustained throughput SHALL be one entry per cycle while out_ready=1.
REQ-012 While wb_valid=1 and out_ready=0, wb_we, wb_rd and wb_data SHALL stay stable.
REQ-013 wb_data SHALL be the source selected by in_sel, computed at capture time.
REQ-014 For in_sel=1, the byte lane SHALL be in_addr_lo[1:0] for byte loads (in_addr_lo[2:0] when XLEN=64), the halfword lane SHALL be in_addr_lo[2:1], and the word lane SHALL be in_addr_lo[2] (word only when XLEN=64). The lane SHALL be sign-extended, or zero-extended when in_ld_uns=1. A word load at XLEN=32 and a dword load at XLEN=64 SHALL pass in_mem unchanged.
REQ-015 wb_we SHALL be wb_valid && in_wen && (in_rd != 0); an entry with rd=0 SHALL still be valid and SHALL retire.
REQ-016 flush SHALL empty main and skid at the next edge. in_valid in a flush cycle SHALL be dropped, and in_ready SHALL be 1 after the edge.
REQ-017 A retire SHALL be an output transfer in a cycle without flush.

Reset
REQ-018 After rst, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, in_ready=1, the skid SHALL be empty, and retire_cnt=0.
REQ-019 rst mid-operation SHALL discard both entries without any write strobe, and rst SHALL take priority over flush and over transfers.

Configuration
REQ-020 With macro WB_RETIRE_CNT_EN defined, retire_cnt SHALL increment by 1 per retire and wrap modulo 2^CNT_W.
REQ-021 Without WB_RETIRE_CNT_EN, retire_cnt SHALL be tied to 0 and no counter flops SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-022 Byte load: sel=1, mem=0x80FF_7F01, addr_lo=1, size=0, uns=0 -> wb_data=0x0000_007F one cycle later; with addr_lo=2 -> 0xFFFF_FFFF.
REQ-023 Half load: mem=0x8001_1234, addr_lo=2, size=1 -> 0xFFFF_8001 signed, 0x0000_8001 unsigned.
REQ-024 Backpressure: 3 back-to-back inputs with out_ready=0 -> first two buffered, in_ready=0 after the second. Raising out_ready -> outputs in order A, B, C with no loss or duplication.
REQ-025 rd=0: wen=1, rd=0, sel=0, alu=0x1234 -> wb_valid=1, wb_we=0, retire_cnt increments by 1.
REQ-026 Flush with both entries full and in_valid=1 -> next cycle wb_valid=0, in_ready=1, no wb_we pulse, retire_cnt unchanged.
REQ-027 Counter wrap: CNT_W=4, 17 retires -> retire_cnt=1; rebuild without WB_RETIRE_CNT_EN -> retire_cnt=0 throughout.
